// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// In-order queue of in-flight predicted branches between the fetch-stage
// predictor and the execute stage. Entries {pc, predict_taken, target} are
// captured at fetch. The oldest entry is checked against the execute outcome,
// which produces a one-cycle resolve pulse for the predictor. A wrong
// prediction raises a one-cycle mispredict with the redirect PC and flushes
// every younger (wrong-path) entry.
//
// Optional feature macro: BRQ_STATS_EN
//   defined   : stat_branches / stat_mispredicts are saturating 16-bit counters
//   undefined : both stat ports are tied to 0
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   push_valid/_pc/_predict_taken/_target   fetch-side branch capture
//   push_ready            entry can be accepted this cycle (combinational)
//   ex_valid/_actual_taken/_target          execute outcome for the oldest entry
//   resolve, actual_taken registered one-cycle pulse to the predictor
//   mispredict            registered one-cycle flush/redirect pulse
//   redirect_pc           correct next PC, valid while mispredict=1, else held
//   count                 registered occupancy
//   stat_branches, stat_mispredicts         statistics (see macro above)
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_valid,
    input  logic [31:0]            push_pc,
    input  logic                   push_predict_taken,
    input  logic [31:0]            push_target,
    output logic                   push_ready,
    input  logic                   ex_valid,
    input  logic                   ex_actual_taken,
    input  logic [31:0]            ex_target,
    output logic                   resolve,
    output logic                   actual_taken,
    output logic                   mispredict,
    output logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            stat_branches,
    output logic [15:0]            stat_mispredicts
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          resolve_q, resolve_d;
    logic          taken_q, taken_d;
    logic          mispredict_q, mispredict_d;
    logic [31:0]   redirect_q, redirect_d;

    // Entry storage.
    logic [31:0]   pc_mem  [DEPTH];
    logic          pt_mem  [DEPTH];
    logic [31:0]   tgt_mem [DEPTH];

    logic          push_acc;
    logic          pop;
    logic          wrong;
    logic          mis;
    logic [31:0]   next_pc;

    // Held low during reset so fetch never sees a ready queue while it is cleared.
    assign push_ready = reset_n && (state_q == RUN) && (count_q < CW'(DEPTH));
    assign push_acc   = push_valid && push_ready;

    // The queue is always empty in RECOVER, so the count test alone blocks pops there.
    assign pop = ex_valid && (count_q != '0) && (state_q == RUN);

    assign wrong = (pt_mem[rd_q] != ex_actual_taken) ||
                   (pt_mem[rd_q] && ex_actual_taken && (tgt_mem[rd_q] != ex_target));
    assign mis   = pop && wrong;

    // 32-bit add wraps naturally: 0xFFFFFFFC + 4 = 0.
    assign next_pc = ex_actual_taken ? ex_target : (pc_mem[rd_q] + 32'd4);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = RUN;
        rd_d         = rd_q;
        wr_d         = wr_q;
        count_d      = count_q;
        resolve_d    = pop;
        taken_d      = pop && ex_actual_taken;
        mispredict_d = mis;
        redirect_d   = redirect_q;

        if (mis) begin
            // Flush everything, including a push offered in this same cycle.
            state_d    = RECOVER;
            rd_d       = '0;
            wr_d       = '0;
            count_d    = '0;
            redirect_d = next_pc;
        end else begin
            if (push_acc) wr_d = wr_q + PW'(1);
            if (pop)      rd_d = rd_q + PW'(1);
            unique case ({push_acc, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            resolve_q    <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            resolve_q    <= resolve_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count/pointers guard every read.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            pc_mem[wr_q]  <= push_pc;
            pt_mem[wr_q]  <= push_predict_taken;
            tgt_mem[wr_q] <= push_target;
        end
    end

    assign resolve      = resolve_q;
    assign actual_taken = taken_q;
    assign mispredict   = mispredict_q;
    assign redirect_pc  = redirect_q;
    assign count        = count_q;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_br_q;
    logic [15:0] stat_mis_q;

    // Saturating counters, updated on the same edge that registers resolve.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (pop && (stat_br_q != 16'hFFFF))  stat_br_q  <= stat_br_q + 16'd1;
            if (mis && (stat_mis_q != 16'hFFFF)) stat_mis_q <= stat_mis_q + 16'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = 16'h0000;
    assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight predicted branches sitting between the fetch-stage GShare predictor and the execute stage. Each entry is captured at fetch, and the oldest entry is checked against the execute-stage outcome. The block then emits a one-cycle resolve pulse with the actual direction, which feeds the predictor's `resolve`/`actual_taken` inputs. On a wrong prediction it raises a mispredict with the redirect PC and discards all younger (wrong-path) entries.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, 2..16.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `push_valid` in 1: fetch presents a predicted branch.
- `push_pc` in 32: PC of the branch.
- `push_predict_taken` in 1: predictor's direction for this branch.
- `push_target` in 32: predicted target (used only if predicted taken).
- `push_ready` out 1: entry can be accepted this cycle.
- `ex_valid` in 1: execute resolves the oldest queued branch this cycle.
- `ex_actual_taken` in 1: actual direction.
- `ex_target` in 32: actual computed target.
- `resolve` out 1: one-cycle pulse to predictor.
- `actual_taken` out 1: direction accompanying `resolve`.
- `mispredict` out 1: one-cycle flush/redirect pulse.
- `redirect_pc` out 32: correct next PC, valid while `mispredict`=1.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `stat_branches` out 16: resolved-branch count (see Configuration).
- `stat_mispredicts` out 16: mispredict count (see Configuration).

## Operation
- Storage: circular buffer with `DEPTH` entries of {pc, predict_taken, target}, read pointer `rd`, write pointer `wr`, and occupancy `count`. Pointers wrap modulo `DEPTH`.
- State machine has two states:
  - RUN: normal operation.
  - RECOVER: one cycle after a mispredict, then unconditionally back to RUN.
- `push_ready` = (state==RUN) && (count<DEPTH). It is combinational and does not depend on the same-cycle `ex_valid`, so there is no full-queue bypass.
- Push: on `push_valid && push_ready`, the entry is written at `wr` and `wr` increments.
- Resolve: `ex_valid` with count>0 pops the entry at `rd`.
  - The outcome is wrong if predict_taken≠ex_actual_taken, or if both are taken and target≠ex_target.
  - The correct next PC is ex_target if ex_actual_taken, else pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0x00000000).
- `ex_valid` with count==0 is ignored: no pop, no pulse, not counted.
- Mispredict: the queue is cleared (rd=wr=0, count=0) and the state goes to RECOVER. A push in that same cycle is discarded even though `push_ready` was 1.
- Push and non-mispredicting resolve in the same cycle: both take effect and count is unchanged.
- Only RUN-state pops are legal. In RECOVER the queue is empty, so `ex_valid` is ignored.

## Timing
- Reset state: all outputs are 0 (`push_ready`=0 while `reset_n`=0, and 1 in the first cycle after release), state=RUN, pointers and count 0, stat counters 0.
- `resolve`, `actual_taken`, `mispredict` and `redirect_pc` are registered. They are asserted for exactly one cycle, in the cycle after the `ex_valid` edge.
- `redirect_pc` holds its last value when `mispredict`=0.
- `count` is registered and updates one cycle after an accepted push or pop.
- Predictor history is updated one cycle after resolution, consistent with the predictor's one-cycle-later resolve convention.
- Reset asserted mid-operation immediately clears the queue, state and outputs; any pending pulses are lost.

## Configuration
- `BRQ_STATS_EN` defined: `stat_branches` increments on every pop, and `stat_mispredicts` increments on every mispredict. Both saturate at 0xFFFF and are registered alongside `resolve`.
- `BRQ_STATS_EN` undefined: both ports remain present, tied to 0, with no counter logic.

## Test plan
- Reset, then push pc=0x100 (predict taken, target 0x200), then ex_valid with taken and target 0x200 -> `resolve`=1, `actual_taken`=1, `mispredict`=0, `count` returns to 0.
- Push pc=0x100 (predict not-taken), then resolve as taken with ex_target 0x180 -> `mispredict`=1, `redirect_pc`=0x180. Next cycle `push_ready`=0 (RECOVER), the following cycle `push_ready`=1.
- Push 4 entries with DEPTH=4 -> `push_ready`=0, `count`=4. A 5th push is held. Resolve one correctly -> `push_ready` returns to 1 the next cycle.
- With 3 queued, the oldest mispredicts (predicted taken, actual not-taken, pc=0xFFFFFFFC) while a push occurs -> `redirect_pc`=0x00000000, `count`=0, the push is discarded.
- `ex_valid` on an empty queue -> no `resolve`, no `mispredict`; with `BRQ_STATS_EN`, stats unchanged.
- Pulse `reset_n` low with 2 entries queued and a resolve pending -> all outputs 0 and `count`=0, with no `resolve` pulse after reset release.
